// File: rtl/wb_arbiter_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : wb_arbiter_pkg
// Purpose  : Shared constants and types for the register-file writeback
//            arbiter and its result FIFO.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package wb_arbiter_pkg;

    // Default datapath widths. The wb_entry_t record is built from these,
    // so the arbiter's WIDTH/ADDR_WIDTH parameters must match them.
    localparam int WB_WIDTH      = 32;
    localparam int WB_ADDR_WIDTH = 5;

    // One pending multi-cycle result: destination register plus its value.
    typedef struct packed {
        logic [WB_ADDR_WIDTH-1:0] rd;
        logic [WB_WIDTH-1:0]      data;
    } wb_entry_t;

    // Which source owns the register-file write port in a given cycle.
    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_PIPE = 2'd1,
        SEL_MC   = 2'd2
    } wb_sel_e;

endpackage : wb_arbiter_pkg
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : wb_fifo
// Purpose  : Circular synchronous FIFO of writeback entries. A push into a
//            full FIFO is dropped even if a pop happens in the same cycle;
//            a pop from an empty FIFO is ignored.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  wb_entry_t       wdata_i,
    input  logic            pop_i,
    output wb_entry_t       rdata_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [CW-1:0]   count_o
);

    wb_entry_t        mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             w_push;
    logic             w_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Qualify requests against the current occupancy only.
    assign w_push = push_i & ~full_o;
    assign w_pop  = pop_i  & ~empty_o;

    // Pointer and occupancy next state; DEPTH is a power of two so the
    // pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule : wb_fifo
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : wb_arbiter
// Purpose  : Drives the integer register-file write port from two sources:
//            the never-stalled single-cycle pipeline and a buffered
//            multi-cycle unit. Tracks per-register pending multi-cycle writes
//            and requests a pipeline bubble when the buffered results starve.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter  int WIDTH        = WB_WIDTH,
    parameter  int ADDR_WIDTH   = WB_ADDR_WIDTH,
    parameter  int DEPTH        = 4,
    parameter  int STARVE_LIMIT = 8,
    localparam int CW           = $clog2(DEPTH + 1),
    localparam int NREG         = 2 ** ADDR_WIDTH,
    localparam int SW           = $clog2(STARVE_LIMIT + 1)
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  pipe_wen,
    input  logic [ADDR_WIDTH-1:0] pipe_rd,
    input  logic [WIDTH-1:0]      pipe_data,
    input  logic                  mc_issue_valid,
    input  logic [ADDR_WIDTH-1:0] mc_issue_rd,
    input  logic                  mc_valid,
    input  logic [ADDR_WIDTH-1:0] mc_rd,
    input  logic [WIDTH-1:0]      mc_data,
    output logic                  mc_ready,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_addr,
    output logic [WIDTH-1:0]      rf_data,
    output logic [NREG-1:0]       busy,
    output logic                  stall_req,
    output logic [CW-1:0]         fifo_count
);

    // Registered outputs and internal state.
    logic                  rf_wen_q,   rf_wen_d;
    logic [ADDR_WIDTH-1:0] rf_addr_q,  rf_addr_d;
    logic [WIDTH-1:0]      rf_data_q,  rf_data_d;
    logic [NREG-1:0]       busy_q,     busy_d;
    logic                  stall_q,    stall_d;
    logic [SW-1:0]         starve_q,   starve_d;

    // FIFO interface.
    wb_entry_t             w_push_entry;
    wb_entry_t             w_head;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_empty_next;
    logic [CW-1:0]         w_count;

    wb_sel_e               w_sel;

    // Results to r0 complete the handshake but are never queued.
    assign mc_ready           = ~w_full;
    assign w_push             = mc_valid & mc_ready & (mc_rd != '0);
    assign w_push_entry.rd    = mc_rd;
    assign w_push_entry.data  = mc_data;

    wb_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk_i   (clock),
        .rst_ni  (clear),
        .push_i  (w_push),
        .wdata_i (w_push_entry),
        .pop_i   (w_pop),
        .rdata_o (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_count)
    );

    // Write-port source selection: a pending stall drains the FIFO first,
    // otherwise the pipeline has priority and the FIFO fills idle slots.
    always_comb begin
        w_sel = SEL_NONE;
        if (stall_q && !w_empty) begin
            w_sel = SEL_MC;
        end else if (pipe_wen && (pipe_rd != '0)) begin
            w_sel = SEL_PIPE;
        end else if (!w_empty) begin
            w_sel = SEL_MC;
        end
    end

    assign w_pop = (w_sel == SEL_MC);

    // Register-file write port; address and data hold when no write occurs.
    always_comb begin
        rf_wen_d  = 1'b0;
        rf_addr_d = rf_addr_q;
        rf_data_d = rf_data_q;
        case (w_sel)
            SEL_PIPE: begin
                rf_wen_d  = 1'b1;
                rf_addr_d = pipe_rd;
                rf_data_d = pipe_data;
            end
            SEL_MC: begin
                rf_wen_d  = 1'b1;
                rf_addr_d = w_head.rd;
                rf_data_d = w_head.data;
            end
            default: begin
                rf_wen_d  = 1'b0;
            end
        endcase
    end

    // Pending-write scoreboard: a new issue overrides a retiring write to
    // the same register, and r0 can never be pending.
    always_comb begin
        busy_d = busy_q;
        if (w_pop) begin
            busy_d[w_head.rd] = 1'b0;
        end
        if (mc_issue_valid && (mc_issue_rd != '0)) begin
            busy_d[mc_issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // FIFO will be empty after this edge. A push into a one-entry FIFO is
    // never blocked because DEPTH is at least two.
    always_comb begin
        if (w_count == CW'(1)) begin
            w_empty_next = w_pop & ~w_push;
        end else begin
            w_empty_next = w_empty & ~w_push;
        end
    end

    // Starvation tracking: count cycles where a queued result is held off
    // by the pipeline; raise the stall once the limit is hit and keep it
    // until the FIFO fully drains.
    always_comb begin
        starve_d = '0;
        if (!w_empty && !w_pop) begin
            if (starve_q == SW'(STARVE_LIMIT)) begin
                starve_d = starve_q;
            end else begin
                starve_d = starve_q + 1'b1;
            end
        end
        stall_d = stall_q;
        if (w_empty_next) begin
            stall_d = 1'b0;
        end else if (starve_d == SW'(STARVE_LIMIT)) begin
            stall_d = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            rf_wen_q  <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
            busy_q    <= '0;
            stall_q   <= 1'b0;
            starve_q  <= '0;
        end else begin
            rf_wen_q  <= rf_wen_d;
            rf_addr_q <= rf_addr_d;
            rf_data_q <= rf_data_d;
            busy_q    <= busy_d;
            stall_q   <= stall_d;
            starve_q  <= starve_d;
        end
    end

    assign rf_wen     = rf_wen_q;
    assign rf_addr    = rf_addr_q;
    assign rf_data    = rf_data_q;
    assign busy       = busy_q;
    assign stall_req  = stall_q;
    assign fifo_count = w_count;

    // Upstream must bubble while a stall is draining the FIFO.
    a_no_pipe_during_stall : assert property (
        @(posedge clock) disable iff (!clear)
        !(stall_q && !w_empty && pipe_wen)
    );

endmodule : wb_arbiter
`default_nettype wire

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback arbiter that drives the write port of the integer register file (regWriteEnable/addrD/dataD).
- Merges two result sources:
  - the in-order single-cycle pipeline writeback, which is never stalled by this block;
  - a multi-cycle unit (divider/FPU) with valid/ready handshake, buffered in a small FIFO.
- Also keeps a per-register busy scoreboard for outstanding multi-cycle results.
- Raises a stall request when the pipeline is starving the FIFO.

Parameters:
- WIDTH, 32, data width of register/result
- ADDR_WIDTH, 5, register index width
- DEPTH, 4, multi-cycle result FIFO entries (power of 2, >=2)
- STARVE_LIMIT, 8, consecutive blocked-pop cycles before stall_req asserts

Ports:
- clock  in  1  sole clock, rising edge
- clear  in  1  asynchronous active-low reset
- pipe_wen  in  1  pipeline writeback valid
- pipe_rd  in  ADDR_WIDTH  pipeline destination register
- pipe_data  in  WIDTH  pipeline result
- mc_issue_valid  in  1  multi-cycle op issued this cycle
- mc_issue_rd  in  ADDR_WIDTH  destination of issued op
- mc_valid  in  1  multi-cycle result valid
- mc_rd  in  ADDR_WIDTH  result destination
- mc_data  in  WIDTH  result data
- mc_ready  out  1  FIFO can accept
- rf_wen  out  1  to regFile regWriteEnable
- rf_addr  out  ADDR_WIDTH  to regFile addrD
- rf_data  out  WIDTH  to regFile dataD
- busy  out  2**ADDR_WIDTH  per-register pending multi-cycle write
- stall_req  out  1  request pipeline bubble
- fifo_count  out  $clog2(DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset (clear=0, async): rf_wen=0, rf_addr=0, rf_data=0, busy=0, stall_req=0, fifo_count=0, FIFO pointers 0, starve counter 0. mc_ready=1 after reset. Reset mid-operation discards all FIFO contents and busy bits.
- mc_ready is combinational: mc_ready = (fifo_count != DEPTH).
  - Push requires mc_valid & mc_ready.
  - No push-through when full, even if a pop occurs in the same cycle.
- mc result with mc_rd==0 is accepted (handshake completes) but not enqueued.
- Per-cycle selection (combinational, registered into rf_* at the rising edge):
  1. stall_req=1 and FIFO nonempty: pop head. pipe_wen must be 0 this cycle (upstream bubbles combinationally on stall_req); pipe_wen=1 here is a protocol violation, flagged by an assertion.
  2. Else pipe_wen=1 and pipe_rd!=0: write pipeline result.
  3. Else FIFO nonempty: pop head.
  4. Else rf_wen=0 next cycle; rf_addr and rf_data hold their previous values.
- Latency:
  - Pipeline input to rf_wen is 1 cycle.
  - mc accepted at edge N: earliest pop at edge N+1, so rf_wen is high after edge N+1.
  - No FIFO bypass.
- FIFO: circular, wrap at DEPTH. Push and pop in the same cycle leave the count unchanged.
- busy:
  - Set busy[mc_issue_rd] on mc_issue_valid when mc_issue_rd != 0.
  - Clear busy[rd] at the edge its FIFO entry pops.
  - Same-cycle set and clear of the same index: set wins.
  - busy[0] is always 0.
- Starvation:
  - Counter increments each cycle the FIFO is nonempty and the pop is blocked by the pipeline.
  - Counter resets to 0 on any pop or when the FIFO is empty.
  - stall_req is registered: it goes 1 at the edge where the counter reaches STARVE_LIMIT, and goes 0 at the edge the FIFO becomes empty.
  - Counter saturates at STARVE_LIMIT.
- Ordering:
  - Multi-cycle results write in acceptance order.
  - WAW hazard between pipe and mc on the same rd is prevented upstream via busy; this block does not check it.

Decomposition:
- Shared package holds:
  - WIDTH/ADDR_WIDTH constants
  - a wb_entry typedef {rd[ADDR_WIDTH], data[WIDTH]}
  - a source-select enum {SEL_NONE, SEL_PIPE, SEL_MC}
- One sub-module: wb_fifo, a synchronous FIFO of wb_entry with push/pop/full/empty/count.
- Arbitration, scoreboard and starve logic stay in wb_arbiter.

Test Plan:
- Reset check: assert clear=0 mid-stream with 2 FIFO entries and busy[5]=1 -> all outputs 0 immediately, mc_ready=1 after release.
- Pipeline only: pipe_wen=1, rd=3, data=0xDEAD_BEEF at edge N -> rf_wen=1, rf_addr=3, rf_data=0xDEADBEEF after N; pipe_rd=0 -> rf_wen=0.
- MC path: issue rd=7 (busy[7]=1); mc_valid rd=7 data=0x1234 accepted at edge N with pipe idle -> rf_wen/rf_addr=7/0x1234 after N+1, busy[7]=0 at the same edge.
- Full/backpressure: DEPTH=4, pipe_wen held 1 with rd!=0, push 4 results -> fifo_count=4, mc_ready=0; fifth mc_valid held until space frees; wrap-around order preserved over 10 entries.
- Starvation: FIFO holds 1 entry, pipe_wen=1 with rd!=0 for 8 cycles -> stall_req=1 at the 8th edge. Then pipe_wen=0 -> head pops next edge, stall_req=0 once the FIFO is empty.
- Same-cycle set/clear: pop of rd=9 coincides with a new issue to rd=9 -> busy[9] stays 1; mc_rd=0 result is handshaken but produces no rf_wen.
